// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory-side signals of the unified
// memory arbiter; slave is the arbiter's view, master the core/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_abort;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_abort,
        output i_rdata, i_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr, i_abort,
        input  i_rdata, i_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data
// ports: round-robin grant in IDLE, then ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    state_t             state_reg;
    port_t              grant_reg;
    port_t              last_grant_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               cancel_reg;
    logic               op_we_reg;
    logic [DATA_W-1:0]  i_rdata_reg;
    logic [DATA_W-1:0]  d_rdata_reg;
    logic               i_ready_reg;
    logic               d_ready_reg;
    logic               mem_en_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;

    logic               grant_d_next;
    logic               abort_now;
    logic               cancel_next;

    // Data port wins unless the fetch port is alone or it was served last.
    always_comb begin
        grant_d_next = 1'b0;
        if (bus.d_req && (!bus.i_req || last_grant_reg == PORT_I)) begin
            grant_d_next = 1'b1;
        end
    end

    // An abort arriving in the capture cycle itself must still suppress the update.
    assign abort_now   = bus.i_abort && (grant_reg == PORT_I) && (state_reg != IDLE);
    assign cancel_next = cancel_reg || abort_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= PORT_I;
            last_grant_reg <= PORT_I;
            cnt_reg        <= '0;
            cancel_reg     <= 1'b0;
            op_we_reg      <= 1'b0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
            i_ready_reg    <= 1'b0;
            d_ready_reg    <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            mem_en_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    cancel_reg <= 1'b0;
                    if (bus.i_req || bus.d_req) begin
                        grant_reg      <= grant_d_next ? PORT_D : PORT_I;
                        last_grant_reg <= grant_d_next ? PORT_D : PORT_I;
                        mem_addr_reg   <= grant_d_next ? bus.d_addr : bus.i_addr;
                        mem_wdata_reg  <= grant_d_next ? bus.d_wdata : '0;
                        mem_we_reg     <= grant_d_next && bus.d_we;
                        op_we_reg      <= grant_d_next && bus.d_we;
                        mem_en_reg     <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt_reg    <= CNT_W'(MEM_LAT - 1);
                    cancel_reg <= cancel_next;
                    state_reg  <= WAIT;
                end

                WAIT: begin
                    cancel_reg <= cancel_next;
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        if (grant_reg == PORT_D) begin
                            d_ready_reg <= 1'b1;
                            if (!op_we_reg) begin
                                d_rdata_reg <= bus.mem_rdata;
                            end
                        end else if (!cancel_next) begin
                            i_ready_reg <= 1'b1;
                            i_rdata_reg <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                RESP: begin
                    cancel_reg <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.i_rdata   = i_rdata_reg;
    assign bus.i_ready   = i_ready_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.d_ready   = d_ready_reg;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT with MEM_LAT=2, one with MEM_LAT=1,
// each fed by a fixed-latency memory model built from a shift register.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] cyc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h40:  word = 32'h8C22_0004;
            32'h00:  word = 32'h2001_0005;
            32'h04:  word = 32'h2002_0007;
            default: word = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory returns the addressed word exactly MEM_LAT cycles after mem_en, junk otherwise.
    logic [31:0] sr2 [0:1];
    logic [31:0] sr1;
    always @(posedge clk) begin
        sr2[0] <= (bus2.mem_en && !bus2.mem_we) ? word(bus2.mem_addr) : (32'hBAD0_0000 | cyc);
        sr2[1] <= sr2[0];
        sr1    <= (bus1.mem_en && !bus1.mem_we) ? word(bus1.mem_addr) : (32'hBAD1_0000 | cyc);
    end
    assign bus2.mem_rdata = sr2[1];
    assign bus1.mem_rdata = sr1;

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus2.i_rdata, bus2.d_rdata, bus2.mem_addr, bus2.mem_wdata,
             bus2.i_ready, bus2.d_ready, bus2.mem_en, bus2.mem_we} !== '0) begin
            miscompares++;
            $display("FAIL reset.dut2_outputs: got i_rdata=%h d_rdata=%h mem_en=%b want all zero",
                     bus2.i_rdata, bus2.d_rdata, bus2.mem_en);
        end
        vectors++;
        if ({bus1.i_rdata, bus1.d_rdata, bus1.mem_addr, bus1.mem_wdata,
             bus1.i_ready, bus1.d_ready, bus1.mem_en, bus1.mem_we} !== '0) begin
            miscompares++;
            $display("FAIL reset.dut1_outputs: got i_rdata=%h mem_en=%b want all zero",
                     bus1.i_rdata, bus1.mem_en);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus2.mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.idle_no_en: got %b want 0", bus2.mem_en);
        end
        $display("reset: outputs checked zero, idle after release");
    endtask

    task automatic test_single_fetch();
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.mem_en !== (k == 1)) begin
                miscompares++;
                $display("FAIL fetch.mem_en c%0d: got %b want %b", k, bus2.mem_en, k == 1);
            end
            vectors++;
            if (bus2.i_ready !== (k == 4) || bus2.d_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch.ready c%0d: got i=%b d=%b want i=%b d=0",
                         k, bus2.i_ready, bus2.d_ready, k == 4);
            end
            if (k == 1) begin
                vectors++;
                if (bus2.mem_addr !== 32'h40 || bus2.mem_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fetch.addr_we: got %h/%b want 00000040/0", bus2.mem_addr, bus2.mem_we);
                end
            end
            if (k == 4) bus2.i_req = 1'b0;
        end
        vectors++;
        if (bus2.i_rdata !== 32'h8C22_0004) begin
            miscompares++;
            $display("FAIL fetch.i_rdata: got %h want 8c220004", bus2.i_rdata);
        end
        $display("single_fetch: addr=0x40 i_rdata=%h", bus2.i_rdata);
    endtask

    task automatic test_write();
        bus2.d_req   = 1'b1;
        bus2.d_we    = 1'b1;
        bus2.d_addr  = 32'h10;
        bus2.d_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.mem_en !== (k == 1) || bus2.mem_we !== (k == 1)) begin
                miscompares++;
                $display("FAIL write.en_we c%0d: got %b/%b want %b/%b",
                         k, bus2.mem_en, bus2.mem_we, k == 1, k == 1);
            end
            vectors++;
            if (bus2.d_ready !== (k == 4) || bus2.i_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL write.ready c%0d: got d=%b i=%b want d=%b i=0",
                         k, bus2.d_ready, bus2.i_ready, k == 4);
            end
            if (k == 1) begin
                vectors++;
                if (bus2.mem_wdata !== 32'hDEAD_BEEF || bus2.mem_addr !== 32'h10) begin
                    miscompares++;
                    $display("FAIL write.bus: got %h@%h want deadbeef@00000010", bus2.mem_wdata, bus2.mem_addr);
                end
            end
            if (k == 4) begin
                bus2.d_req = 1'b0;
                bus2.d_we  = 1'b0;
            end
        end
        vectors++;
        if (bus2.d_rdata !== 32'h0 || bus2.i_rdata !== 32'h8C22_0004) begin
            miscompares++;
            $display("FAIL write.retain: got d=%h i=%h want 00000000/8c220004", bus2.d_rdata, bus2.i_rdata);
        end
        $display("write: addr=0x10 data=deadbeef d_rdata=%h", bus2.d_rdata);
    endtask

    task automatic test_conflict();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h8;
        bus2.d_req  = 1'b1;
        bus2.d_we   = 1'b0;
        bus2.d_addr = 32'h20;
        for (int k = 1; k <= 20; k++) begin
            logic exp_en;
            logic exp_d;
            logic exp_i;
            exp_en = (k == 1) || (k == 6) || (k == 11) || (k == 16);
            exp_d  = (k == 4) || (k == 14);
            exp_i  = (k == 9) || (k == 19);
            @(negedge clk);
            vectors++;
            if (bus2.mem_en !== exp_en || bus2.d_ready !== exp_d || bus2.i_ready !== exp_i) begin
                miscompares++;
                $display("FAIL conflict.seq c%0d: got en=%b d=%b i=%b want en=%b d=%b i=%b",
                         k, bus2.mem_en, bus2.d_ready, bus2.i_ready, exp_en, exp_d, exp_i);
            end
            if (exp_en) begin
                vectors++;
                if (bus2.mem_addr !== ((k == 1 || k == 11) ? 32'h20 : 32'h8)) begin
                    miscompares++;
                    $display("FAIL conflict.grant c%0d: got addr %h want %h",
                             k, bus2.mem_addr, (k == 1 || k == 11) ? 32'h20 : 32'h8);
                end
            end
            if (k == 19) begin
                bus2.i_req = 1'b0;
                bus2.d_req = 1'b0;
            end
        end
        vectors++;
        if (bus2.d_rdata !== word(32'h20) || bus2.i_rdata !== word(32'h8)) begin
            miscompares++;
            $display("FAIL conflict.rdata: got d=%h i=%h want %h/%h",
                     bus2.d_rdata, bus2.i_rdata, word(32'h20), word(32'h8));
        end
        $display("conflict: grants D,I,D,I d_rdata=%h i_rdata=%h", bus2.d_rdata, bus2.i_rdata);
    endtask

    task automatic test_abort();
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h44;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.mem_en !== (k == 1) || bus2.i_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL abort.seq c%0d: got en=%b i_ready=%b want en=%b i_ready=0",
                         k, bus2.mem_en, bus2.i_ready, k == 1);
            end
            if (k == 1) begin
                vectors++;
                if (bus2.mem_addr !== 32'h44) begin
                    miscompares++;
                    $display("FAIL abort.addr: got %h want 00000044", bus2.mem_addr);
                end
            end
            if (k == 2) begin
                bus2.i_abort = 1'b1;
                bus2.i_req   = 1'b0;
            end
            if (k == 3) bus2.i_abort = 1'b0;
        end
        vectors++;
        if (bus2.i_rdata !== word(32'h8)) begin
            miscompares++;
            $display("FAIL abort.retain: got %h want %h", bus2.i_rdata, word(32'h8));
        end
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.i_ready !== (k == 4)) begin
                miscompares++;
                $display("FAIL abort.next_ready c%0d: got %b want %b", k, bus2.i_ready, k == 4);
            end
            if (k == 4) bus2.i_req = 1'b0;
        end
        vectors++;
        if (bus2.i_rdata !== 32'h8C22_0004) begin
            miscompares++;
            $display("FAIL abort.next_rdata: got %h want 8c220004", bus2.i_rdata);
        end
        $display("abort: fetch 0x44 cancelled, follow-up i_rdata=%h", bus2.i_rdata);
    endtask

    task automatic test_reset_mid();
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h4C;
        @(negedge clk);
        vectors++;
        if (bus2.mem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid.mem_en: got %b want 1", bus2.mem_en);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus2.i_rdata, bus2.d_rdata, bus2.mem_addr, bus2.mem_wdata,
             bus2.i_ready, bus2.d_ready, bus2.mem_en, bus2.mem_we} !== '0) begin
            miscompares++;
            $display("FAIL rstmid.async_clear: got i_rdata=%h d_rdata=%h mem_addr=%h want zero",
                     bus2.i_rdata, bus2.d_rdata, bus2.mem_addr);
        end
        bus2.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.i_ready !== 1'b0 || bus2.d_ready !== 1'b0 || bus2.mem_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid.quiet c%0d: got i=%b d=%b en=%b want 0/0/0",
                         k, bus2.i_ready, bus2.d_ready, bus2.mem_en);
            end
        end
        bus2.i_req  = 1'b1;
        bus2.i_addr = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus2.i_ready !== (k == 4)) begin
                miscompares++;
                $display("FAIL rstmid.refetch c%0d: got %b want %b", k, bus2.i_ready, k == 4);
            end
            if (k == 4) bus2.i_req = 1'b0;
        end
        vectors++;
        if (bus2.i_rdata !== 32'h8C22_0004) begin
            miscompares++;
            $display("FAIL rstmid.rdata: got %h want 8c220004", bus2.i_rdata);
        end
        $display("reset_mid: outputs cleared, refetch i_rdata=%h", bus2.i_rdata);
    endtask

    task automatic test_back_to_back();
        bus1.i_req  = 1'b1;
        bus1.i_addr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (bus1.mem_en !== (k == 1 || k == 5) || bus1.i_ready !== (k == 3 || k == 7)) begin
                miscompares++;
                $display("FAIL b2b.seq c%0d: got en=%b i_ready=%b want en=%b i_ready=%b",
                         k, bus1.mem_en, bus1.i_ready, k == 1 || k == 5, k == 3 || k == 7);
            end
            if (k == 3) begin
                vectors++;
                if (bus1.i_rdata !== 32'h2001_0005) begin
                    miscompares++;
                    $display("FAIL b2b.word0: got %h want 20010005", bus1.i_rdata);
                end
                bus1.i_addr = 32'h4;
            end
            if (k == 7) begin
                vectors++;
                if (bus1.i_rdata !== 32'h2002_0007) begin
                    miscompares++;
                    $display("FAIL b2b.word1: got %h want 20020007", bus1.i_rdata);
                end
                bus1.i_req = 1'b0;
            end
        end
        $display("back_to_back: MEM_LAT=1 fetches 0x0,0x4 i_rdata=%h", bus1.i_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.i_abort = 1'b0;
        bus2.d_req = 1'b0; bus2.d_we = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.i_abort = 1'b0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
        rst = 1'b1;
        test_reset();
        test_single_fetch();
        test_write();
        test_conflict();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
